// File: rtl/imem_fetch_buffered_pkg.sv
// Shared constants for the buffered instruction memory: NOP word, boot image
// and the big-endian byte-lane helpers.
package imem_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam int          BOOT_WORDS = 5;

  localparam logic [31:0] BOOT_IMAGE [BOOT_WORDS] = '{
    32'h8C41_000A,  // lw   r1,r2,10
    32'hAC61_0005,  // sw   r1,r3,5
    32'h00A3_1025,  // or   r2,r5,r3
    32'h00C7_0825,  // or   r1,r6,r7
    32'h3061_000A   // andi r1,r3,10
  };

  // Lane 0 is the most significant byte (lowest address).
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] boot_byte(input int idx);
    logic [7:0] b;
    logic [2:0] w;
    w = 3'(idx / 4);
    if (idx < BOOT_WORDS * 4) begin
      b = be_byte(BOOT_IMAGE[w], 2'(idx % 4));
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

endpackage

// File: rtl/imem_fetch_buffered_rsp_fifo.sv
// Two-entry response FIFO of {pc, instr, fault}. The head lives in dedicated
// registers so the outputs come straight from flops and hold while stalled.
module imem_rsp_fifo #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_pc,
  input  logic [31:0]     push_instr,
  input  logic            push_fault,
  output logic [1:0]      count,
  output logic            head_valid,
  output logic [PC_W-1:0] head_pc,
  output logic [31:0]     head_instr,
  output logic            head_fault
);

  logic [1:0]      count_q, count_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [31:0]     head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
  logic            head_fault_q, head_fault_d, tail_fault_q, tail_fault_d;

  // Next-state: the tail shifts into the head on pop, new words land in the
  // first free slot; flush clears everything.
  always_comb begin
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    head_fault_d = head_fault_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    tail_fault_d = tail_fault_q;
    if (flush) begin
      count_d      = 2'd0;
      head_pc_d    = '0;
      head_instr_d = 32'h0000_0000;
      head_fault_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d    = push_pc;
            head_instr_d = push_instr;
            head_fault_d = push_fault;
            count_d      = 2'd1;
          end else begin
            tail_pc_d    = push_pc;
            tail_instr_d = push_instr;
            tail_fault_d = push_fault;
            count_d      = 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            head_fault_d = tail_fault_q;
          end else begin
            head_pc_d    = head_pc_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            head_fault_d = tail_fault_q;
            tail_pc_d    = push_pc;
            tail_instr_d = push_instr;
            tail_fault_d = push_fault;
          end else begin
            head_pc_d    = push_pc;
            head_instr_d = push_instr;
            head_fault_d = push_fault;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    valid_d = (count_d != 2'd0);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      valid_q      <= 1'b0;
      head_pc_q    <= '0;
      head_instr_q <= 32'h0000_0000;
      head_fault_q <= 1'b0;
      tail_pc_q    <= '0;
      tail_instr_q <= 32'h0000_0000;
      tail_fault_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      valid_q      <= valid_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      head_fault_q <= head_fault_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_fault_q <= tail_fault_d;
    end
  end

  assign count      = count_q;
  assign head_valid = valid_q;
  assign head_pc    = head_pc_q;
  assign head_instr = head_instr_q;
  assign head_fault = head_fault_q;

endmodule

// File: rtl/imem_fetch_buffered.sv
// Byte-addressed big-endian instruction memory with a 2-entry response buffer
// and a word program port. Define IMEM_PRELOAD_EN to load the boot image on reset.
module imem_fetch_buffered
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [PC_W-1:0] req_pc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_instr,
  output logic [PC_W-1:0] rsp_pc,
  output logic            rsp_fault,
  input  logic            flush,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [31:0]     prog_data
);

  localparam int              AW           = $clog2(DEPTH_BYTES);
  localparam logic [PC_W-1:0] LAST_WORD_PC = PC_W'(DEPTH_BYTES - 4);
  localparam logic [PC_W-1:0] LAST_BYTE_PC = PC_W'(DEPTH_BYTES - 1);

  logic [7:0]  mem_q [DEPTH_BYTES];
  logic [7:0]  mem_d [DEPTH_BYTES];
  logic [1:0]  count_s;
  logic        accept_s;
  logic        pop_s;
  logic        fault_s;
  logic        prog_hit_s;
  logic [31:0] rd_instr_s;

  assign req_ready = (count_s < 2'd2) && !flush;
  assign accept_s  = req_valid && req_ready;
  assign pop_s     = rsp_valid && rsp_ready;
  assign fault_s   = (req_pc[1:0] != 2'b00) || (req_pc > LAST_WORD_PC);

  // OR-ing in the ignored low bits makes the range check use the word base.
  assign prog_hit_s = prog_we && ((prog_addr | PC_W'(2'd3)) <= LAST_BYTE_PC);

  // Array read: faulting fetches never touch the array and return a NOP.
  always_comb begin
    if (fault_s) begin
      rd_instr_s = NOP;
    end else begin
      rd_instr_s = {mem_q[{req_pc[AW-1:2], 2'd0}], mem_q[{req_pc[AW-1:2], 2'd1}],
                    mem_q[{req_pc[AW-1:2], 2'd2}], mem_q[{req_pc[AW-1:2], 2'd3}]};
    end
  end

  // Program port: one big-endian word per cycle, writes past the end dropped.
  always_comb begin
    mem_d = mem_q;
    if (prog_hit_s) begin
      mem_d[{prog_addr[AW-1:2], 2'd0}] = be_byte(prog_data, 2'd0);
      mem_d[{prog_addr[AW-1:2], 2'd1}] = be_byte(prog_data, 2'd1);
      mem_d[{prog_addr[AW-1:2], 2'd2}] = be_byte(prog_data, 2'd2);
      mem_d[{prog_addr[AW-1:2], 2'd3}] = be_byte(prog_data, 2'd3);
    end else begin
      mem_d = mem_q;
    end
  end

`ifdef IMEM_PRELOAD_EN
  // Array storage, reloaded with the boot image on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[AW'(i)] <= boot_byte(i);
      end
    end else begin
      mem_q <= mem_d;
    end
  end
`else
  // Array storage without reset; contents come only from the program port.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`endif

  imem_rsp_fifo #(
    .PC_W(PC_W)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush      (flush),
    .push       (accept_s),
    .pop        (pop_s),
    .push_pc    (req_pc),
    .push_instr (rd_instr_s),
    .push_fault (fault_s),
    .count      (count_s),
    .head_valid (rsp_valid),
    .head_pc    (rsp_pc),
    .head_instr (rsp_instr),
    .head_fault (rsp_fault)
  );

endmodule

// File: tb/tb_imem_fetch_buffered.sv
// Directed bench for imem_fetch_buffered: fetch order, faults, back-pressure,
// program collisions, flush and asynchronous reset.
module tb_imem_fetch_buffered;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic        rsp_fault;
  logic        flush;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [31:0] boot [5] = '{32'h8C41000A, 32'hAC610005, 32'h00A31025,
                            32'h00C70825, 32'h3061000A};

  imem_fetch_buffered #(.DEPTH_BYTES(64), .PC_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_pc = 32'd0; rsp_ready = 1'b0;
    flush = 1'b0; prog_we = 1'b0; prog_addr = 32'd0; prog_data = 32'd0;
    repeat (3) tick();
    check("reset_valid", rsp_valid, 1'b0);
    check("reset_instr", rsp_instr, 32'h0);
    check("reset_pc", rsp_pc, 32'h0);
    check("reset_fault", rsp_fault, 1'b0);
    check("reset_ready", req_ready, 1'b1);
    reset = 1'b1;
    tick();

`ifdef IMEM_PRELOAD_EN
    rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'd0;
    tick();
    check("preload_pc0", rsp_instr, 32'h8C41000A);
    req_valid = 1'b0;
    tick();
`endif

    // Load the boot image, a word at byte 63 (-> word 60), and an out-of-range write.
    for (int k = 0; k < 5; k++) begin
      prog_we = 1'b1; prog_addr = 32'(4 * k); prog_data = boot[k];
      tick();
    end
    prog_addr = 32'd63; prog_data = 32'h12345678;
    tick();
    prog_addr = 32'd64; prog_data = 32'hFFFFFFFF;
    tick();
    prog_we = 1'b0;

    // In-order back-to-back fetch.
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_pc = 32'(4 * k);
      tick();
      check($sformatf("seq_valid_%0d", k), rsp_valid, 1'b1);
      check($sformatf("seq_instr_%0d", k), rsp_instr, boot[k]);
      check($sformatf("seq_pc_%0d", k), rsp_pc, 32'(4 * k));
      check($sformatf("seq_fault_%0d", k), rsp_fault, 1'b0);
      check($sformatf("seq_ready_%0d", k), req_ready, 1'b1);
    end
    req_valid = 1'b0;
    tick();
    check("seq_drain", rsp_valid, 1'b0);

    // Faults and range boundaries.
    req_valid = 1'b1; req_pc = 32'd6;
    tick();
    check("mis_instr", rsp_instr, 32'h0);
    check("mis_fault", rsp_fault, 1'b1);
    check("mis_pc", rsp_pc, 32'd6);
    req_pc = 32'd64;
    tick();
    check("oor_fault", rsp_fault, 1'b1);
    check("oor_instr", rsp_instr, 32'h0);
    check("oor_pc", rsp_pc, 32'd64);
    req_pc = 32'd60;
    tick();
    check("last_fault", rsp_fault, 1'b0);
    check("last_instr", rsp_instr, 32'h12345678);
    req_pc = 32'd0;
    tick();
    check("noalias_instr", rsp_instr, 32'h8C41000A);
    req_valid = 1'b0;
    tick();
    check("fault_drain", rsp_valid, 1'b0);

    // Back-pressure.
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd0;
    tick();
    check("bp_ready_1", req_ready, 1'b1);
    check("bp_head_pc_1", rsp_pc, 32'd0);
    req_pc = 32'd4;
    tick();
    check("bp_ready_full", req_ready, 1'b0);
    check("bp_head_instr", rsp_instr, 32'h8C41000A);
    req_pc = 32'd8;
    tick();
    check("bp_hold_pc", rsp_pc, 32'd0);
    check("bp_hold_instr", rsp_instr, 32'h8C41000A);
    check("bp_hold_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    tick();
    check("bp_pop_pc", rsp_pc, 32'd4);
    check("bp_pop_instr", rsp_instr, 32'hAC610005);
    check("bp_pop_ready", req_ready, 1'b1);
    tick();
    check("bp_pc8_pc", rsp_pc, 32'd8);
    check("bp_pc8_instr", rsp_instr, 32'h00A31025);
    req_valid = 1'b0;
    tick();
    check("bp_drain", rsp_valid, 1'b0);

    // Program write colliding with a fetch of the same word.
    req_valid = 1'b1; req_pc = 32'd4;
    prog_we = 1'b1; prog_addr = 32'd4; prog_data = 32'hDEADBEEF;
    tick();
    prog_we = 1'b0;
    check("coll_old", rsp_instr, 32'hAC610005);
    tick();
    check("coll_new", rsp_instr, 32'hDEADBEEF);
    req_valid = 1'b0;
    tick();

    // Flush with two entries buffered, then flush blocking an accept.
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd0;
    tick();
    req_pc = 32'd8;
    tick();
    check("fl_full_valid", rsp_valid, 1'b1);
    check("fl_full_ready", req_ready, 1'b0);
    req_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("fl_valid", rsp_valid, 1'b0);
    check("fl_ready", req_ready, 1'b1);
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'd0;
    #1;
    check("fl_ready_gated", req_ready, 1'b0);
    tick();
    check("fl_drop", rsp_valid, 1'b0);
    flush = 1'b0;

    // Asynchronous reset mid-stream.
    tick();
    req_pc = 32'd16;
    tick();
    check("rst_pre_full", req_ready, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_instr", rsp_instr, 32'h0);
    check("rst_pc", rsp_pc, 32'h0);
    check("rst_fault", rsp_fault, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rst_post_valid", rsp_valid, 1'b0);
    rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'd0;
    tick();
    check("rst_refetch", rsp_instr, 32'h8C41000A);
    req_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
